// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the execute-stage branch resolution controller.
package branch_ctrl_pkg;

    // Resolution sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } br_state_e;

    // Low PC bits that must be zero for a legal fetch target
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Processor branch op encodings (funct3 style)
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_NOP  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Branch condition from precomputed compare flags; unknown ops are not taken
    function automatic logic br_cond(input logic [2:0] op, input logic eq,
                                     input logic lt_s, input logic lt_u);
        logic r;
        case (op)
            BR_BEQ:  r = eq;
            BR_BNE:  r = ~eq;
            BR_BLT:  r = lt_s;
            BR_BGE:  r = ~lt_s;
            BR_BLTU: r = lt_u;
            BR_BGEU: r = ~lt_u;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch condition and target evaluation.
module branch_cond_eval
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] pc,
    input  logic [12:0]     imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken_c,
    output logic            misalign_c,
    output logic [XLEN-1:0] target_c
);

    logic [XLEN-1:0] imm_sx;
    assign imm_sx = XLEN'($signed(imm));

    // Compare operands, form the wrapping target and flag misaligned taken targets
    always_comb begin
        target_c   = pc + imm_sx;
        taken_c    = br_cond(op, rs1 == rs2, $signed(rs1) < $signed(rs2), rs1 < rs2);
        misalign_c = taken_c & ((target_c[1:0] & ALIGN_MASK) != 2'b00);
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution sequencer: accept, evaluate, redirect, flush.
// Optional macro BR_PREDICT_EN adds prediction input and a mispredict counter.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
`ifdef BR_PREDICT_EN
    input  logic             br_pred_taken,
    output logic [CNT_W-1:0] mispredict_count,
`endif
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_control,
    input  logic [XLEN-1:0] br_pc,
    input  logic [12:0]     br_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            resolve_valid,
    output logic            resolve_taken,
    output logic            resolve_misalign,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    localparam int unsigned FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? '0 : FW'(FLUSH_CYCLES - 1);

    br_state_e       state, state_n;
    logic [FW-1:0]   cnt, cnt_n;
    logic            accept_c;
    logic [2:0]      op_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q;
    logic [12:0]     imm_q;
    logic            taken_c, misalign_c, redirect_c;
    logic [XLEN-1:0] target_c, redirect_target_c;

    branch_cond_eval #(.XLEN(XLEN)) u_eval (
        .op         (op_q),
        .pc         (pc_q),
        .imm        (imm_q),
        .rs1        (rs1_q),
        .rs2        (rs2_q),
        .taken_c    (taken_c),
        .misalign_c (misalign_c),
        .target_c   (target_c)
    );

`ifdef BR_PREDICT_EN
    logic pred_q;
    logic mispredict_c;

    // Redirect only when outcome disagrees with prediction; misaligned taken always counts
    always_comb begin
        redirect_c        = (taken_c != pred_q) && !misalign_c;
        mispredict_c      = (taken_c != pred_q) || misalign_c;
        redirect_target_c = taken_c ? target_c : pc_q + XLEN'(4);
    end

    // Saturating mispredict counter, bumped once per resolved branch
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count <= '0;
            pred_q           <= 1'b0;
        end else begin
            if (accept_c) pred_q <= br_pred_taken;
            if (state == EVAL && mispredict_c && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused        = '0;
    assign redirect_c        = taken_c & ~misalign_c;
    assign redirect_target_c = target_c;
`endif

    // Resolution result is presented for the single EVAL cycle
    assign resolve_valid    = (state == EVAL);
    assign resolve_taken    = resolve_valid & taken_c;
    assign resolve_misalign = resolve_valid & misalign_c;

    // Next-state and flush counter
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid && br_ready) begin
                    accept_c = 1'b1;
                    state_n  = EVAL;
                end
            end
            EVAL: begin
                state_n = redirect_c ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = FLUSH;
                        cnt_n   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - FW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // State, captured branch and registered handshake/flush outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= BR_NOP;
            pc_q           <= '0;
            imm_q          <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            br_ready       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            br_ready       <= (state_n == IDLE);
            redirect_valid <= (state_n == REDIRECT);
            flush          <= (state_n == FLUSH);
            if (accept_c) begin
                op_q  <= br_control;
                pc_q  <= br_pc;
                imm_q <= br_imm;
                rs1_q <= rs1_data;
                rs2_q <= rs2_data;
            end
            if (state == EVAL && state_n == REDIRECT)
                redirect_pc <= redirect_target_c;
        end
    end

endmodule
